pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central sequencing controller for the five-stage MIPS pipeline: it detects load-use and branch/jump hazards, generates the enable/flush controls for the PC and the IF_ID, ID_EX and EX_MEM pipeline registers, and computes operand-forwarding selects for the EX-stage ALU inputs. It also owns the syscall halt/resume state machine that gates the PC. It sits beside the pipeline registers, clocked by the divided core clock, and replaces the tied-off stall/zero controls.

## Interface
- REG_BITS, 5, register index width
- CNT_BITS, 32, width of performance counters (only with HAZARD_PERF_CNT_EN)
- clk  in  1  divided core clock (clk_N domain)
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_BITS  source registers decoded in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs/rt
- ex_write  in  REG_BITS  EX destination; ex_reg_write in 1; ex_mem_to_reg in 1 (EX is a load)
- mem_write  in  REG_BITS  MEM destination; mem_reg_write in 1
- wb_write  in  REG_BITS  WB destination; wb_reg_write in 1
- ex_rs, ex_rt  in  REG_BITS  sources of the instruction in EX
- ex_redirect  in  1  taken branch / Jmp / Jr / Jal resolved in EX
- ex_syscall  in  1; ex_v0_is_34  in  1  (syscall in EX is a display call)
- go  in  1  resume button level
- pc_en, ifid_en, idex_en  out  1  register load enables (1 = load)
- ifid_flush, idex_flush, exmem_flush  out  1  synchronous bubble insert (register cleared on next edge)
- fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 01 EX_MEM result, 10 MEM_WB write data
- halted  out  1  FSM in HALT
- stall_cnt, flush_cnt, halt_cnt  out  CNT_BITS  (only with HAZARD_PERF_CNT_EN)

## Operation
- FSM states: RUN, HALT. Reset -> RUN.
- RUN -> HALT: ex_syscall=1 and ex_v0_is_34=0 on a clock edge. HALT -> RUN: rising edge of go (go registered into go_q; edge = go & ~go_q). go held high in RUN has no effect.
- Load-use hazard (RUN only): ex_mem_to_reg & ex_reg_write & ex_write!=0 & ((id_use_rs & id_rs==ex_write) | (id_use_rt & id_rt==ex_write)). Response: pc_en=0, ifid_en=0, idex_flush=1.
- Redirect (RUN only): ex_redirect=1 -> ifid_flush=1, idex_flush=1, pc_en=1 (PC loads target). Redirect overrides load-use in the same cycle (the stalled instruction is squashed).
- HALT entry cycle and HALT state: pc_en=0, ifid_en=0, idex_en=0, idex_flush=0, exmem_flush=1 while in HALT (EX instruction retires once, no repeats); older stages drain.
- Priority: HALT > redirect > load-use > normal (all enables 1, flushes 0).
- Forwarding, per operand (ex_rs -> fwd_a, ex_rt -> fwd_b): 01 if mem_reg_write & mem_write==src & src!=0; else 10 if wb_reg_write & wb_write==src & src!=0; else 00. Register 0 never forwards. Forwarding is purely combinational and independent of FSM state.
- Reset mid-operation: FSM to RUN, go_q to 0, counters to 0 immediately (async).

## Timing
- All control outputs combinational from inputs and current state; zero-cycle latency, sampled by pipeline registers on the next clk edge.
- Reset values (rst_n=0): halted=0; control outputs reflect RUN with idle inputs (pc_en=ifid_en=idex_en=1, all flushes 0, fwd_a=fwd_b=00); counters 0.
- Load-use costs exactly one bubble: hazard deasserts next cycle as the load has moved to MEM.
- Redirect costs two squashed slots (IF and ID).
- Resume: go edge at edge N -> halted=0 and pc_en=1 from edge N onward.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt increments each RUN cycle with load-use active and no redirect; flush_cnt each cycle with redirect in RUN; halt_cnt each cycle in HALT. Counters saturate at all-ones, never wrap.
- Undefined: counter ports and logic absent; control behaviour identical.

## Structure
- Shared package: fwd select encodings (FWD_REG, FWD_EXMEM, FWD_MEMWB), FSM state typedef (ST_RUN, ST_HALT).
- One sub-module: hazard_fwd_unit (combinational forwarding compare for one operand, instantiated twice).

## Test plan
- Load r2 in EX (ex_write=2, ex_mem_to_reg=1), ID reads rs=2 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_cnt=1.
- Same as above with id_rs=0, ex_write=0 -> no stall.
- ex_redirect=1 together with load-use condition -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- mem_write=5 and wb_write=5, both writing, ex_rs=5 -> fwd_a=01; drop mem_reg_write -> fwd_a=10; ex_rt=0 with wb_write=0 -> fwd_b=00.
- ex_syscall=1, ex_v0_is_34=0 -> halted=1, pc_en=0 for 10 cycles with go low; go held high before halt ignored; go rising -> halted=0 same edge; halt_cnt=10. With ex_v0_is_34=1 -> no halt.
- Assert rst_n low while halted and counters nonzero -> immediately halted=0, counters 0, pc_en=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;  // register file read data
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // result held in EX_MEM
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // write data held in MEM_WB

    // Syscall halt/resume state machine
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand forwarding compare for one EX-stage ALU source register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
//
// Ports: src (EX source register), mem_write/mem_reg_write (MEM destination),
//        wb_write/wb_reg_write (WB destination), fwd (operand select).
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0] src,
    input  logic [REG_BITS-1:0] mem_write,
    input  logic                mem_reg_write,
    input  logic [REG_BITS-1:0] wb_write,
    input  logic                wb_reg_write,
    output logic [1:0]          fwd
);

    // The younger producer (MEM) wins over the older one (WB); r0 is hardwired zero.
    always_comb begin
        fwd = FWD_REG;
        if (src != '0) begin
            if (mem_reg_write && (mem_write == src)) begin
                fwd = FWD_EXMEM;
            end else if (wb_reg_write && (wb_write == src)) begin
                fwd = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stall, redirect squash, syscall halt/resume, ALU operand forwarding.
// Latency: controls are combinational from inputs and state (zero cycles); halted is registered state.
// Backpressure: stalls PC/IF_ID on load-use, freezes PC/IF_ID/ID_EX while halted until a go rising edge.
//
// Ports: ID sources (id_rs/id_rt/id_use_*), EX/MEM/WB destinations and write flags,
//        EX sources (ex_rs/ex_rt), ex_redirect, ex_syscall/ex_v0_is_34, go button;
//        outputs pc/ifid/idex enables, ifid/idex/exmem flushes, fwd_a/fwd_b, halted.
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall_cnt/flush_cnt/halt_cnt counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_BITS = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [REG_BITS-1:0] ex_write,
    input  logic                ex_reg_write,
    input  logic                ex_mem_to_reg,
    input  logic [REG_BITS-1:0] mem_write,
    input  logic                mem_reg_write,
    input  logic [REG_BITS-1:0] wb_write,
    input  logic                wb_reg_write,
    input  logic [REG_BITS-1:0] ex_rs,
    input  logic [REG_BITS-1:0] ex_rt,
    input  logic                ex_redirect,
    input  logic                ex_syscall,
    input  logic                ex_v0_is_34,
    input  logic                go,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                idex_en,
    output logic                ifid_flush,
    output logic                idex_flush,
    output logic                exmem_flush,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [CNT_BITS-1:0] flush_cnt,
    output logic [CNT_BITS-1:0] halt_cnt
`endif
);

    hazard_state_t state;
    logic          go_q;

    logic in_run;
    logic in_halt;
    logic halt_entry;
    logic redirect;
    logic load_use;
    logic rs_hit;
    logic rt_hit;

    assign in_run  = (state == ST_RUN);
    assign in_halt = (state == ST_HALT);

    // A non-display syscall in EX freezes the front end in the same cycle it is seen.
    assign halt_entry = in_run && ex_syscall && !ex_v0_is_34;
    assign redirect   = in_run && ex_redirect;

    assign rs_hit   = id_use_rs && (id_rs == ex_write);
    assign rt_hit   = id_use_rt && (id_rt == ex_write);
    assign load_use = in_run && ex_mem_to_reg && ex_reg_write && (ex_write != '0)
                      && (rs_hit || rt_hit);

    // Halt/resume FSM; go is sampled every cycle so a level held across the
    // halt entry does not count as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            go_q   <= 1'b0;
            halted <= 1'b0;
        end else begin
            go_q <= go;
            case (state)
                ST_RUN: begin
                    if (ex_syscall && !ex_v0_is_34) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (go && !go_q) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Priority: halt > redirect > load-use > normal flow.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (in_halt || halt_entry) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            // The syscall moves into EX_MEM on the entry edge; while halted it
            // stays parked in ID_EX, so EX_MEM gets bubbles instead of repeats.
            exmem_flush = in_halt;
        end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    hazard_fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_a (
        .src           (ex_rs),
        .mem_write     (mem_write),
        .mem_reg_write (mem_reg_write),
        .wb_write      (wb_write),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_a)
    );

    hazard_fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_b (
        .src           (ex_rt),
        .mem_write     (mem_write),
        .mem_reg_write (mem_reg_write),
        .wb_write      (wb_write),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_b)
    );

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // Saturating event counters; stalls squashed by a redirect are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            halt_cnt  <= '0;
        end else begin
            if (load_use && !redirect && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (in_halt && (halt_cnt != CNT_MAX)) begin
                halt_cnt <= halt_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
